// File: rtl/tick_ctrl.sv
// tick_ctrl: single-clock run/step sequencer that turns a selectable prescaler
// tap into a one-cycle tick enable for the counter-adder datapath.
// The tap register picks the prescaler bit. The tick period is 2^(tap+1)
// cycles, which matches stage `tap` of a T-flip-flop divider chain.
// No derived clock is created anywhere in this block.
module tick_ctrl #(
    parameter int CNT_W = 21,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       state,
    output logic [SEL_W-1:0] tap,
    output logic [7:0]       tick_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    // Highest legal tap. Larger requests are clamped to this value.
    localparam logic [SEL_W-1:0] TAP_MAX = SEL_W'(CNT_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   tap_q, tap_d;
    logic               tick_q, tick_d;
    logic [7:0]         tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]   tap_mask_s;
    logic               tick_cond_s;

    // Clamp a requested tap onto the implemented prescaler range.
    function automatic logic [SEL_W-1:0] sat_tap(input logic [SEL_W-1:0] sel);
        logic [SEL_W-1:0] res;
        if (sel > TAP_MAX) begin
            res = TAP_MAX;
        end else begin
            res = sel;
        end
        return res;
    endfunction

    // Build the thermometer mask cnt[tap:0] and detect when all masked bits are set.
    always_comb begin
        tap_mask_s = {CNT_W{1'b0}};
        for (int i = 0; i < CNT_W; i++) begin
            if (i <= int'(tap_q)) begin
                tap_mask_s[i] = 1'b1;
            end else begin
                tap_mask_s[i] = 1'b0;
            end
        end
        tick_cond_s = &(cnt_q | ~tap_mask_s);
    end

    // Sequencer next state, prescaler, tap write and tick decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The tap is only writable while idle, so a write on the
                // same edge as start is in place for the first run cycle.
                if (cfg_we) begin
                    tap_d = sat_tap(cfg_sel);
                end else begin
                    tap_d = tap_q;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (step) begin
                    state_d = ST_STEP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // stop wins over a tick condition on the same edge.
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    tick_d  = tick_cond_s;
                end
            end
            ST_STEP: begin
                // Leave STEP on the edge that raises the single tick.
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    tick_d = tick_cond_s;
                    if (tick_cond_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        tick_cnt_d = tick_cnt_q + {7'd0, tick_d};
    end

    // State, prescaler, tap, tick and tick counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            tap_q      <= TAP_MAX;
            tick_q     <= 1'b0;
            tick_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tap_q      <= tap_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick     = tick_q;
    assign busy     = (state_q != ST_IDLE);
    assign state    = state_q;
    assign tap      = tap_q;
    assign tick_cnt = tick_cnt_q;

endmodule
